// File: rtl/fire_fm_serializer_if.sv
// Bus between a layer's parallel channel-vector output and the serializer that
// replays it as a pixel stream for the next layer.
interface fire_fm_serializer_if #(
  parameter int WIDTH = 16,
  parameter int CHIN  = 64
);
  logic                          in_valid;
  logic [0:CHIN-1][WIDTH-1:0]    in_vec;
  logic                          start;
  logic                          fill_done;
  logic                          ovf;
  logic                          layer_en;
  logic [WIDTH-1:0]              ifm;
  logic                          ifm_valid;
  logic                          win_start;
  logic                          stream_end;

  modport master (
    output in_valid, in_vec, start,
    input  fill_done, ovf, layer_en, ifm, ifm_valid, win_start, stream_end
  );

  modport slave (
    input  in_valid, in_vec, start,
    output fill_done, ovf, layer_en, ifm, ifm_valid, win_start, stream_end
  );
endinterface

// File: rtl/fire_fm_serializer.sv
// Captures one channel vector per spatial position, then streams the map out
// channel-major per position with GAP idle cycles after each window.
//
// state  | meaning
// IDLE   | after reset, waiting for the first vector
// FILL   | capturing positions 1..POS-1
// FULL   | buffer complete, waiting for start
// STREAM | replaying windows (drain flag covers the final output cycle)
// DONE   | map streamed, stream_end held until a new fill begins
module fire_fm_serializer #(
  parameter int WIDTH = 16,
  parameter int CHIN  = 64,
  parameter int W_IN  = 16,
  parameter int H_IN  = 16,
  parameter int GAP   = 1,
  parameter int POS   = W_IN * H_IN
) (
  input  logic                 clk,
  input  logic                 rst,
  fire_fm_serializer_if.slave  bus
);

  localparam int PW  = (POS > 1) ? $clog2(POS) : 1;
  localparam int CW  = (CHIN + GAP > 1) ? $clog2(CHIN + GAP) : 1;
  localparam int CIW = (CHIN > 1) ? $clog2(CHIN) : 1;

  localparam logic [PW-1:0] POS_LAST     = PW'(POS - 1);
  localparam logic [CW-1:0] CH_DATA_LAST = CW'(CHIN - 1);
  localparam logic [CW-1:0] CH_LAST      = CW'(CHIN + GAP - 1);

  typedef enum logic [2:0] {IDLE, FILL, FULL, STREAM, DONE} state_t;

  state_t                     state;
  logic [PW-1:0]              wr_pos;
  logic [PW-1:0]              rd_pos;
  logic [CW-1:0]              ch;
  logic                       drain;
  logic                       fill_done;
  logic                       ovf;
  logic                       layer_en;
  logic [WIDTH-1:0]           ifm;
  logic                       ifm_valid;
  logic                       win_start;
  logic                       stream_end;
  logic                       accept;
  logic [0:CHIN-1][WIDTH-1:0] mem [0:POS-1];

  // wr_pos is already 0 in IDLE and DONE, so one write path serves all fills
  assign accept = bus.in_valid && (state == IDLE || state == FILL || state == DONE);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_pos] <= bus.in_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_pos     <= '0;
      rd_pos     <= '0;
      ch         <= '0;
      drain      <= 1'b0;
      fill_done  <= 1'b0;
      ovf        <= 1'b0;
      layer_en   <= 1'b0;
      ifm        <= '0;
      ifm_valid  <= 1'b0;
      win_start  <= 1'b0;
      stream_end <= 1'b0;
    end else begin
      if (accept) begin
        stream_end <= 1'b0;
        layer_en   <= 1'b0;
        if (wr_pos == POS_LAST) begin
          wr_pos    <= '0;
          state     <= FULL;
          fill_done <= 1'b1;
        end else begin
          wr_pos <= wr_pos + 1'b1;
          state  <= FILL;
        end
      end

      case (state)
        FULL: begin
          if (bus.in_valid) ovf <= 1'b1;
          if (bus.start) begin
            state    <= STREAM;
            layer_en <= 1'b1;
            rd_pos   <= '0;
            ch       <= '0;
            drain    <= 1'b0;
          end
        end
        STREAM: begin
          if (bus.in_valid) ovf <= 1'b1;
          if (drain) begin
            state      <= DONE;
            stream_end <= 1'b1;
            layer_en   <= 1'b0;
            fill_done  <= 1'b0;
            drain      <= 1'b0;
            ifm        <= '0;
            ifm_valid  <= 1'b0;
            win_start  <= 1'b0;
          end else begin
            // read is registered: the counters lead the outputs by one cycle
            if (ch <= CH_DATA_LAST) begin
              ifm       <= mem[rd_pos][ch[CIW-1:0]];
              ifm_valid <= 1'b1;
              win_start <= (ch == '0);
            end else begin
              ifm       <= '0;
              ifm_valid <= 1'b0;
              win_start <= 1'b0;
            end
            if (ch == CH_LAST) begin
              ch <= '0;
              if (rd_pos == POS_LAST) begin
                rd_pos <= '0;
                drain  <= 1'b1;
              end else begin
                rd_pos <= rd_pos + 1'b1;
              end
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fill_done  = fill_done;
  assign bus.ovf        = ovf;
  assign bus.layer_en   = layer_en;
  assign bus.ifm        = ifm;
  assign bus.ifm_valid  = ifm_valid;
  assign bus.win_start  = win_start;
  assign bus.stream_end = stream_end;

endmodule

// File: tb/tb_fire_fm_serializer.sv
// Directed bench: 2x2 map of 4-channel vectors, GAP=1 instance plus a GAP=0
// instance for the back-to-back window case.
module tb_fire_fm_serializer;
  localparam int WIDTH = 16;
  localparam int CHIN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fire_fm_serializer_if #(.WIDTH(WIDTH), .CHIN(CHIN)) bus_a ();
  fire_fm_serializer_if #(.WIDTH(WIDTH), .CHIN(CHIN)) bus_b ();

  fire_fm_serializer #(.WIDTH(WIDTH), .CHIN(CHIN), .W_IN(2), .H_IN(2), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  fire_fm_serializer #(.WIDTH(WIDTH), .CHIN(CHIN), .W_IN(2), .H_IN(2), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic junk_a();
    for (int c = 0; c < CHIN; c++) bus_a.in_vec[c] = 16'hDEAD;
  endtask

  task automatic zeros_a(input string tag);
    chk({tag, "_fill_done"}, 32'(bus_a.fill_done), 0);
    chk({tag, "_ovf"}, 32'(bus_a.ovf), 0);
    chk({tag, "_layer_en"}, 32'(bus_a.layer_en), 0);
    chk({tag, "_ifm"}, 32'(bus_a.ifm), 0);
    chk({tag, "_ifm_valid"}, 32'(bus_a.ifm_valid), 0);
    chk({tag, "_win_start"}, 32'(bus_a.win_start), 0);
    chk({tag, "_stream_end"}, 32'(bus_a.stream_end), 0);
  endtask

  task automatic fill_a(input int base, input int mul, input int idle);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < CHIN; c++) bus_a.in_vec[c] = 16'(base + p * mul + c);
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      chk("fill_done", 32'(bus_a.fill_done), 32'(p == 3));
      if (p == 0) chk("stream_end_clr", 32'(bus_a.stream_end), 0);
      if (p < 3) begin
        for (int i = 0; i < idle; i++) begin
          tick();
          chk("fill_done_idle", 32'(bus_a.fill_done), 0);
        end
      end
    end
  endtask

  task automatic stream_a(input int base, input int mul, input int ncyc,
                          input int inject_at, input bit strobe_with_start);
    int p, c;
    bus_a.start = 1'b1;
    bus_a.in_valid = strobe_with_start;
    junk_a();
    tick();
    bus_a.start = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("lat_layer_en", 32'(bus_a.layer_en), 1);
    chk("lat_ifm_valid", 32'(bus_a.ifm_valid), 0);
    for (int k = 0; k < ncyc; k++) begin
      p = k / 5;
      c = k % 5;
      if (k == inject_at) begin
        junk_a();
        bus_a.in_valid = 1'b1;
      end
      tick();
      bus_a.in_valid = 1'b0;
      chk("ifm", 32'(bus_a.ifm), (c < 4) ? 32'(base + p * mul + c) : 0);
      chk("ifm_valid", 32'(bus_a.ifm_valid), 32'(c < 4));
      chk("win_start", 32'(bus_a.win_start), 32'(c == 0));
      chk("layer_en", 32'(bus_a.layer_en), 1);
      chk("stream_end_low", 32'(bus_a.stream_end), 0);
    end
    if (ncyc == 20) begin
      tick();
      chk("end_stream_end", 32'(bus_a.stream_end), 1);
      chk("end_layer_en", 32'(bus_a.layer_en), 0);
      chk("end_fill_done", 32'(bus_a.fill_done), 0);
      chk("end_ifm_valid", 32'(bus_a.ifm_valid), 0);
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.in_vec   = '0;
    bus_b.in_valid = 1'b0;
    bus_b.start    = 1'b0;
    bus_b.in_vec   = '0;

    #2 rst = 1'b0;
    #1 zeros_a("reset");
    tick();
    rst = 1'b1;

    // first fill, back-to-back strobes
    fill_a(0, 16, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nostart_ifm_valid", 32'(bus_a.ifm_valid), 0);
      chk("nostart_layer_en", 32'(bus_a.layer_en), 0);
    end

    // fifth strobe while FULL
    junk_a();
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    chk("ovf_full", 32'(bus_a.ovf), 1);
    chk("ovf_full_fill_done", 32'(bus_a.fill_done), 1);

    stream_a(0, 16, 20, -1, 1'b0);

    // re-arm from DONE with sparse strobes; start and strobe together in FULL
    fill_a(100, 4, 3);
    stream_a(100, 4, 12, -1, 1'b1);

    // abort at window 2 channel 1
    #2 rst = 1'b0;
    #1 zeros_a("abort");
    tick();
    rst = 1'b1;

    fill_a(0, 16, 0);
    chk("ovf_after_reset", 32'(bus_a.ovf), 0);
    stream_a(0, 16, 20, 7, 1'b0);
    chk("ovf_stream", 32'(bus_a.ovf), 1);

    fill_a(100, 4, 0);
    stream_a(100, 4, 20, -1, 1'b0);

    // GAP=0 instance: contiguous 16-cycle stream
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < CHIN; c++) bus_b.in_vec[c] = 16'(p * 16 + c);
      bus_b.in_valid = 1'b1;
      tick();
      bus_b.in_valid = 1'b0;
    end
    chk("g0_fill_done", 32'(bus_b.fill_done), 1);
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    chk("g0_layer_en", 32'(bus_b.layer_en), 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("g0_ifm", 32'(bus_b.ifm), 32'((k / 4) * 16 + (k % 4)));
      chk("g0_ifm_valid", 32'(bus_b.ifm_valid), 1);
      chk("g0_win_start", 32'(bus_b.win_start), 32'((k % 4) == 0));
    end
    tick();
    chk("g0_stream_end", 32'(bus_b.stream_end), 1);
    chk("g0_end_valid", 32'(bus_b.ifm_valid), 0);
    chk("g0_end_layer_en", 32'(bus_b.layer_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fire_fm_serializer.md
Name: fire_fm_serializer

Overview:
- Bridges a layer's parallel output to the next layer's serial input. Captures per-position channel vectors (`ofm[0:CHIN-1]`, one strobe per spatial position) into a position-indexed buffer.
- Once the buffer is full and `start` is seen, replays the feature map as a 16-bit pixel stream, channel-major per position.
- Inserts GAP idle cycles after each window, so a downstream 1x1 expand MAC array with a (CHIN+1)-cycle clear period stays aligned.

Parameters:
- WIDTH, 16, pixel/channel word width
- CHIN, 64, channels per spatial position (vector length written, pixels streamed per window)
- W_IN, 16, feature-map width
- H_IN, 16, feature-map height
- GAP, 1, idle cycles after each window's last channel (matches consumer clear cycle)
- POS, W_IN*H_IN, positions held in buffer (derived)

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  capture strobe for in_vec (one position per strobe)
- in_vec  input  WIDTH x [0:CHIN-1]  channel vector for the current position
- start  input  1  request to begin streaming (level, sampled per cycle)
- fill_done  output  1  buffer holds POS positions
- ovf  output  1  sticky: in_valid arrived while not accepting
- layer_en  output  1  consumer enable; high for the whole stream
- ifm  output  WIDTH  streamed pixel
- ifm_valid  output  1  ifm carries a real pixel
- win_start  output  1  pulse with channel 0 of each window
- stream_end  output  1  level; whole map streamed

Behaviour:
- Reset (async, rst=0): state IDLE; write position counter, read position counter and channel counter = 0. All outputs 0: fill_done, ovf, layer_en, ifm, ifm_valid, win_start, stream_end. Buffer contents undefined. Reset mid-fill or mid-stream aborts immediately; there is no resume.
- States: IDLE, FILL, FULL, STREAM, DONE.
- IDLE / DONE, in_valid=1:
  - Store in_vec at position 0; write counter = 1; go to FILL.
  - Entering FILL from DONE clears stream_end and layer_en.
- FILL, in_valid=1:
  - Store at the write counter and increment it.
  - The strobe that writes position POS-1 moves to FULL. fill_done goes high on the following edge; the write counter wraps to 0.
- FULL / STREAM, in_valid=1: vector dropped, ovf set (sticky until rst).
- Strobes need not be consecutive; gaps of any length are legal.
- FULL, start=1 sampled at edge N:
  - Go to STREAM; layer_en=1 from N+1.
  - Buffer read is registered, so the first pixel appears with ifm_valid=1 and win_start=1 at N+2.
  - start is ignored in every other state.
- STREAM timing:
  - Each window is CHIN cycles of ifm_valid=1 carrying channels 0..CHIN-1 of the current position, in order.
  - These are followed by GAP cycles of ifm_valid=0, ifm=0.
  - Window period is CHIN+GAP cycles; position order is 0..POS-1.
  - win_start is high only on the channel-0 cycle.
- Stream end:
  - After the GAP cycles of position POS-1, go to DONE. stream_end=1 and layer_en=0 on the same edge; fill_done cleared.
  - stream_end stays high until the next fill begins or rst.
- Counter rules:
  - Channel counter is clog2(CHIN+GAP) bits and wraps at CHIN+GAP-1.
  - Position counters are clog2(POS) bits with an explicit compare at POS-1; no reliance on natural overflow.
- Data is not modified; no arithmetic on data.
- Simultaneous events:
  - in_valid plus start in FULL: start wins and in_valid sets ovf.
  - in_valid on the edge that enters DONE: dropped with ovf. Only in_valid in DONE itself starts a new fill.
- GAP=0: windows stream back-to-back with no ifm_valid=0 cycles.

Test Plan:
- Fill and stream, CHIN=4, W_IN=H_IN=2, GAP=1. Write vectors {p*16+c}, then start -> 20-cycle stream reading 0,1,2,3,bubble,16,17,18,19,bubble,... . win_start on cycles 0,5,10,15; stream_end=1 at cycle 20; layer_en 1 throughout.
- Latency check: start at edge N -> layer_en at N+1, first ifm_valid with win_start at N+2; start held low in FULL -> no ifm_valid ever.
- Overflow: a 5th in_valid in FULL, and an in_valid mid-STREAM -> ovf=1, stream data unchanged (position 0 still 0..3).
- Sparse writes: in_valid with 3 idle cycles between strobes -> fill_done only after the 4th strobe; streamed data identical to back-to-back fill.
- Reset mid-stream at window 2 channel 1 -> all outputs 0 asynchronously, state IDLE; a new fill then stream completes correctly.
- Re-arm: after DONE, a new fill with {100+p*4+c} -> stream_end clears on first strobe; second stream outputs new values; GAP=0 build gives a contiguous 16-cycle stream.
